arp_req_sched: RTL and testbench
================================

Name: arp_req_sched

Overview:
- Controller that drives the ARP transmit packetiser's trigger inputs (arp_reply pulse, arp_active pulse, active destination IP).
- Arbitrates between two sources:
  - peer ARP requests needing a reply;
  - local MAC-resolution requests from the IP layer.
- Runs a per-lookup timeout/retry sequence until a matching ARP reply arrives or retries are exhausted.
- Sits between the ARP receive parser, the IP TX path and the ARP packetiser.

Parameters:
- P_TIMEOUT_CYC, 16'd50000, cycles to wait for a reply after a request frame completes.
- P_MAX_RETRY, 3, request transmissions after the first before declaring failure.
- P_MIN_GAP, 8, idle cycles forced between consecutive trigger pulses.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_lookup_ip  in  32  IP to resolve; sampled when i_lookup_valid=1.
- i_lookup_valid  in  1  one-cycle lookup request pulse.
- o_lookup_busy  out  1  1 while a lookup is in progress; new lookups are ignored.
- i_rx_req_valid  in  1  pulse: peer ARP request addressed to us was parsed.
- i_rx_rsp_valid  in  1  pulse: ARP reply parsed.
- i_rx_rsp_ip  in  32  sender IP of the parsed reply.
- i_rx_rsp_mac  in  48  sender MAC of the parsed reply.
- o_arp_reply  out  1  one-cycle trigger: send a reply.
- o_arp_active  out  1  one-cycle trigger: send a request.
- o_arp_active_dst_ip  out  32  target IP; valid with o_arp_active.
- i_tx_ready  in  1  packetiser ready (AXIS ready of the ARP stream).
- i_tx_valid  in  1  packetiser AXIS valid (monitored).
- i_tx_last  in  1  packetiser AXIS last (monitored).
- o_resolved_mac  out  48  resolved MAC.
- o_resolved_ip  out  32  resolved IP.
- o_resolved_valid  out  1  one-cycle resolution-success pulse.
- o_lookup_fail  out  1  one-cycle failure pulse after retries are exhausted.

Behaviour:

Reset (i_rst_n=0 at a clock edge):
- All outputs 0.
- Both FSMs return to IDLE; counters and pending flags cleared.
- Reset mid-frame abandons tracking. The packetiser is not notified.

Reply pending flag:
- Set by i_rx_req_valid.
- Repeated i_rx_req_valid while set is merged into one reply.
- Cleared in the cycle o_arp_reply is asserted.

TX arbiter FSM, states TX_IDLE -> TX_BUSY -> TX_GAP -> TX_IDLE:
- In TX_IDLE with i_tx_ready=1, one issue per cycle.
- Priority: pending reply over pending request.
- Issue means a registered one-cycle pulse on o_arp_reply or o_arp_active, then move to TX_BUSY.
- o_arp_reply and o_arp_active are never high together.
- TX_BUSY exits on i_tx_valid & i_tx_ready & i_tx_last, then enters TX_GAP.
- TX_GAP lasts P_MIN_GAP cycles, then TX_IDLE.
- Request sent when the frame's last beat is accepted generates a tx_done event for the lookup FSM.

Lookup FSM, states L_IDLE, L_ISSUE, L_WAIT_TX, L_WAIT_RSP:
- L_IDLE: on i_lookup_valid, latch i_lookup_ip into o_arp_active_dst_ip, clear retry count, go to L_ISSUE. o_lookup_busy=1 in every state except L_IDLE.
- L_ISSUE: request is pending to the arbiter. On grant (o_arp_active pulse) go to L_WAIT_TX.
- L_WAIT_TX: on tx_done, load the timer with P_TIMEOUT_CYC and go to L_WAIT_RSP.
- L_WAIT_RSP: the timer decrements each cycle.
  - Match (i_rx_rsp_valid and i_rx_rsp_ip == latched IP): register mac/ip, pulse o_resolved_valid the next cycle, go to L_IDLE.
  - Timer reaching 0 with retry count < P_MAX_RETRY: increment count, go to L_ISSUE.
  - Timer reaching 0 with retry count == P_MAX_RETRY: pulse o_lookup_fail, go to L_IDLE.
- A match in the same cycle the timer reaches 0 counts as success.
- A reply with a non-matching IP is ignored.
- A matching reply seen in L_ISSUE or L_WAIT_TX is also accepted as success. The in-flight frame is still tracked to completion by the arbiter.
- A timer of 0 never wraps.

Latency:
- i_lookup_valid to o_arp_active: 2 cycles when the arbiter is idle and i_tx_ready=1.
- i_rx_req_valid to o_arp_reply: 2 cycles under the same conditions.

Width rules:
- Timer is 16 bits; retry counter is 4 bits.
- o_resolved_mac and o_resolved_ip hold their value until the next success.

Test Plan:
1. Lookup 192.168.100.10 with i_tx_ready=1 -> o_arp_active at +2 cycles with dst_ip C0A8640A. Drive last beat, then a matching reply with MAC 00_11_22_33_44_55 -> o_resolved_valid pulse with that MAC; o_lookup_busy falls.
2. Lookup with no reply, P_TIMEOUT_CYC=100, P_MAX_RETRY=3 -> exactly 4 o_arp_active pulses, each ≥100 cycles after the prior last beat; then one o_lookup_fail pulse.
3. i_rx_req_valid and i_lookup_valid in the same cycle -> o_arp_reply first. o_arp_active follows only after that frame's last beat plus P_MIN_GAP idle cycles.
4. Three i_rx_req_valid pulses while TX_BUSY -> exactly one further o_arp_reply.
5. Reply from IP C0A86405 during a lookup of C0A8640A -> ignored; timeout and retry proceed.
6. Assert i_rst_n=0 for 1 cycle during L_WAIT_RSP -> all outputs 0 next cycle and o_lookup_busy=0. A new lookup then works as in scenario 1.

Source files
------------

// File: rtl/arp_req_sched.sv
// ARP transmit scheduler: arbitrates peer-reply and local-lookup triggers into the
// ARP packetiser and runs the per-lookup timeout/retry sequence.
module arp_req_sched #(
    parameter logic [15:0] P_TIMEOUT_CYC = 16'd50000,
    parameter int          P_MAX_RETRY   = 3,
    parameter int          P_MIN_GAP     = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lookup_ip,
    input  logic        i_lookup_valid,
    output logic        o_lookup_busy,
    input  logic        i_rx_req_valid,
    input  logic        i_rx_rsp_valid,
    input  logic [31:0] i_rx_rsp_ip,
    input  logic [47:0] i_rx_rsp_mac,
    output logic        o_arp_reply,
    output logic        o_arp_active,
    output logic [31:0] o_arp_active_dst_ip,
    input  logic        i_tx_ready,
    input  logic        i_tx_valid,
    input  logic        i_tx_last,
    output logic [47:0] o_resolved_mac,
    output logic [31:0] o_resolved_ip,
    output logic        o_resolved_valid,
    output logic        o_lookup_fail
);

    typedef enum logic [1:0] {TX_IDLE, TX_BUSY, TX_GAP} tx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_ISSUE, L_WAIT_TX, L_WAIT_RSP} lk_state_t;

    localparam logic [3:0] MAX_RETRY = 4'(P_MAX_RETRY);
    localparam logic [7:0] GAP_LAST  = 8'(P_MIN_GAP - 1);

    tx_state_t   tx_state, tx_next;
    lk_state_t   lk_state, lk_next;
    logic        reply_pend;
    logic        cur_is_req;
    logic [7:0]  gap_cnt;
    logic [15:0] timer;
    logic [3:0]  retry_cnt;

    logic        beat_last;
    logic        rsp_match;
    logic        req_pend;
    logic        tx_done;
    logic        issue_reply;
    logic        issue_req;
    logic        success;
    logic        fail;
    logic        retry;

    assign beat_last = i_tx_valid & i_tx_ready & i_tx_last;
    assign rsp_match = i_rx_rsp_valid && (i_rx_rsp_ip == o_arp_active_dst_ip);
    // A reply that resolves the lookup while still in L_ISSUE withdraws the request.
    assign req_pend  = (lk_state == L_ISSUE) && !rsp_match;
    assign tx_done   = (tx_state == TX_BUSY) && cur_is_req && beat_last;

    always_comb begin
        tx_next     = tx_state;
        issue_reply = 1'b0;
        issue_req   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (i_tx_ready) begin
                    if (reply_pend) begin
                        issue_reply = 1'b1;
                        tx_next     = TX_BUSY;
                    end else if (req_pend) begin
                        issue_req = 1'b1;
                        tx_next   = TX_BUSY;
                    end
                end
            end
            TX_BUSY: if (beat_last) tx_next = TX_GAP;
            TX_GAP:  if (gap_cnt == GAP_LAST) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tx_state     <= TX_IDLE;
            gap_cnt      <= 8'd0;
            cur_is_req   <= 1'b0;
            reply_pend   <= 1'b0;
            o_arp_reply  <= 1'b0;
            o_arp_active <= 1'b0;
        end else begin
            tx_state     <= tx_next;
            o_arp_reply  <= issue_reply;
            o_arp_active <= issue_req;
            if (issue_reply || issue_req)
                cur_is_req <= issue_req;
            gap_cnt <= (tx_state == TX_GAP) ? gap_cnt + 8'd1 : 8'd0;
            // A new peer request arriving on the issue edge must not be lost.
            if (i_rx_req_valid)
                reply_pend <= 1'b1;
            else if (issue_reply)
                reply_pend <= 1'b0;
        end
    end

    always_comb begin
        lk_next       = lk_state;
        o_lookup_busy = (lk_state != L_IDLE);
        success       = 1'b0;
        fail          = 1'b0;
        retry         = 1'b0;
        case (lk_state)
            L_IDLE: if (i_lookup_valid) lk_next = L_ISSUE;
            L_ISSUE: begin
                if (rsp_match) begin
                    success = 1'b1;
                    lk_next = L_IDLE;
                end else if (issue_req) begin
                    lk_next = L_WAIT_TX;
                end
            end
            L_WAIT_TX: begin
                if (rsp_match) begin
                    success = 1'b1;
                    lk_next = L_IDLE;
                end else if (tx_done) begin
                    lk_next = L_WAIT_RSP;
                end
            end
            L_WAIT_RSP: begin
                if (rsp_match) begin
                    success = 1'b1;
                    lk_next = L_IDLE;
                end else if (timer == 16'd0) begin
                    if (retry_cnt >= MAX_RETRY) begin
                        fail    = 1'b1;
                        lk_next = L_IDLE;
                    end else begin
                        retry   = 1'b1;
                        lk_next = L_ISSUE;
                    end
                end
            end
            default: lk_next = L_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lk_state            <= L_IDLE;
            timer               <= 16'd0;
            retry_cnt           <= 4'd0;
            o_arp_active_dst_ip <= 32'd0;
            o_resolved_mac      <= 48'd0;
            o_resolved_ip       <= 32'd0;
            o_resolved_valid    <= 1'b0;
            o_lookup_fail       <= 1'b0;
        end else begin
            lk_state         <= lk_next;
            o_resolved_valid <= success;
            o_lookup_fail    <= fail;
            if (lk_state == L_IDLE && i_lookup_valid) begin
                o_arp_active_dst_ip <= i_lookup_ip;
                retry_cnt           <= 4'd0;
            end else if (retry) begin
                retry_cnt <= retry_cnt + 4'd1;
            end
            if (success) begin
                o_resolved_mac <= i_rx_rsp_mac;
                o_resolved_ip  <= o_arp_active_dst_ip;
            end
            if (lk_state == L_WAIT_TX && tx_done)
                timer <= P_TIMEOUT_CYC;
            else if (lk_state == L_WAIT_RSP && timer != 16'd0)
                timer <= timer - 16'd1;
        end
    end

endmodule

// File: tb/tb_arp_req_sched.sv
// Directed bench for arp_req_sched: lookup success, retry/fail, arbitration,
// reply merging, foreign-reply rejection and mid-lookup reset.
module tb_arp_req_sched;

    localparam int TMO = 100;
    localparam int GAP = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] lookup_ip;
    logic        lookup_valid;
    logic        lookup_busy;
    logic        rx_req_valid;
    logic        rx_rsp_valid;
    logic [31:0] rx_rsp_ip;
    logic [47:0] rx_rsp_mac;
    logic        arp_reply;
    logic        arp_active;
    logic [31:0] dst_ip;
    logic        tx_ready;
    logic        tx_valid;
    logic        tx_last;
    logic [47:0] res_mac;
    logic [31:0] res_ip;
    logic        res_valid;
    logic        lookup_fail;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int last_cyc = 0;

    arp_req_sched #(
        .P_TIMEOUT_CYC(16'(TMO)),
        .P_MAX_RETRY  (3),
        .P_MIN_GAP    (GAP)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_lookup_ip        (lookup_ip),
        .i_lookup_valid     (lookup_valid),
        .o_lookup_busy      (lookup_busy),
        .i_rx_req_valid     (rx_req_valid),
        .i_rx_rsp_valid     (rx_rsp_valid),
        .i_rx_rsp_ip        (rx_rsp_ip),
        .i_rx_rsp_mac       (rx_rsp_mac),
        .o_arp_reply        (arp_reply),
        .o_arp_active       (arp_active),
        .o_arp_active_dst_ip(dst_ip),
        .i_tx_ready         (tx_ready),
        .i_tx_valid         (tx_valid),
        .i_tx_last          (tx_last),
        .o_resolved_mac     (res_mac),
        .o_resolved_ip      (res_ip),
        .o_resolved_valid   (res_valid),
        .o_lookup_fail      (lookup_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame;
        tx_valid = 1'b1;
        tx_last  = 1'b0;
        tick();
        tx_last = 1'b1;
        tick();
        last_cyc = cyc;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_active(input int bound, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (arp_active) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic start_lookup(input logic [31:0] ip);
        lookup_ip    = ip;
        lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic [31:0] ip, input logic [47:0] mac);
        rx_rsp_ip    = ip;
        rx_rsp_mac   = mac;
        rx_rsp_valid = 1'b1;
        tick();
        rx_rsp_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (arp_reply !== 1'b0)   begin fails++; $display("FAIL rst_reply got %b want 0", arp_reply); end
        checks++; if (arp_active !== 1'b0)  begin fails++; $display("FAIL rst_active got %b want 0", arp_active); end
        checks++; if (lookup_busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", lookup_busy); end
        checks++; if (dst_ip !== 32'd0)     begin fails++; $display("FAIL rst_dst got %h want 0", dst_ip); end
        checks++; if (res_mac !== 48'd0 || res_valid !== 1'b0 || lookup_fail !== 1'b0)
            begin fails++; $display("FAIL rst_res got mac=%h v=%b f=%b want 0", res_mac, res_valid, lookup_fail); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lookup_ok;
        start_lookup(32'hC0A8640A);
        checks++; if (lookup_busy !== 1'b1) begin fails++; $display("FAIL ok_busy got %b want 1", lookup_busy); end
        checks++; if (arp_active !== 1'b0)  begin fails++; $display("FAIL ok_early got %b want 0", arp_active); end
        tick();
        checks++; if (arp_active !== 1'b1)  begin fails++; $display("FAIL ok_active got %b want 1", arp_active); end
        checks++; if (dst_ip !== 32'hC0A8640A) begin fails++; $display("FAIL ok_dst got %h want C0A8640A", dst_ip); end
        tick();
        checks++; if (arp_active !== 1'b0)  begin fails++; $display("FAIL ok_pulse got %b want 0", arp_active); end
        send_frame();
        repeat (5) tick();
        send_rsp(32'hC0A8640A, 48'h001122334455);
        checks++; if (res_valid !== 1'b1)   begin fails++; $display("FAIL ok_valid got %b want 1", res_valid); end
        checks++; if (res_mac !== 48'h001122334455) begin fails++; $display("FAIL ok_mac got %h want 001122334455", res_mac); end
        checks++; if (res_ip !== 32'hC0A8640A) begin fails++; $display("FAIL ok_ip got %h want C0A8640A", res_ip); end
        checks++; if (lookup_busy !== 1'b0) begin fails++; $display("FAIL ok_idle got %b want 0", lookup_busy); end
        tick();
        checks++; if (res_valid !== 1'b0 || res_mac !== 48'h001122334455)
            begin fails++; $display("FAIL ok_hold got v=%b mac=%h want 0/001122334455", res_valid, res_mac); end
        repeat (GAP + 2) tick();
    endtask

    task automatic test_retry_fail;
        bit seen;
        int pulses = 0;
        int extra  = 0;
        int d;
        start_lookup(32'hC0A80001);
        for (int n = 0; n < 4; n++) begin
            wait_active(300, seen);
            checks++; if (!seen) begin fails++; $display("FAIL rf_pulse%0d got none want pulse", n); end
            if (seen) pulses++;
            if (n > 0) begin
                d = cyc - last_cyc;
                checks++; if (d < TMO || d > TMO + 10)
                    begin fails++; $display("FAIL rf_spacing%0d got %0d want %0d..%0d", n, d, TMO, TMO + 10); end
            end
            tick();
            send_frame();
        end
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (lookup_fail) begin
                seen = 1'b1;
                break;
            end
            if (arp_active) extra++;
            tick();
        end
        checks++; if (!seen)      begin fails++; $display("FAIL rf_fail got none want pulse"); end
        checks++; if (pulses + extra !== 4) begin fails++; $display("FAIL rf_count got %0d want 4", pulses + extra); end
        checks++; if (lookup_busy !== 1'b0) begin fails++; $display("FAIL rf_busy got %b want 0", lookup_busy); end
        tick();
        checks++; if (lookup_fail !== 1'b0) begin fails++; $display("FAIL rf_once got %b want 0", lookup_fail); end
        repeat (GAP + 2) tick();
    endtask

    task automatic test_priority;
        bit seen;
        rx_req_valid = 1'b1;
        lookup_ip    = 32'hC0A86414;
        lookup_valid = 1'b1;
        tick();
        rx_req_valid = 1'b0;
        lookup_valid = 1'b0;
        tick();
        checks++; if (arp_reply !== 1'b1 || arp_active !== 1'b0)
            begin fails++; $display("FAIL pri_first got reply=%b active=%b want 1/0", arp_reply, arp_active); end
        tick();
        send_frame();
        wait_active(50, seen);
        checks++; if (!seen) begin fails++; $display("FAIL pri_active got none want pulse"); end
        checks++; if (cyc - last_cyc !== GAP + 1)
            begin fails++; $display("FAIL pri_gap got %0d want %0d", cyc - last_cyc, GAP + 1); end
        checks++; if (arp_reply !== 1'b0) begin fails++; $display("FAIL pri_excl got %b want 0", arp_reply); end
        tick();
        send_frame();
        send_rsp(32'hC0A86414, 48'hA0A1A2A3A4A5);
        checks++; if (res_valid !== 1'b1 || res_mac !== 48'hA0A1A2A3A4A5)
            begin fails++; $display("FAIL pri_res got v=%b mac=%h want 1/A0A1A2A3A4A5", res_valid, res_mac); end
        repeat (GAP + 2) tick();
    endtask

    task automatic test_merge;
        int replies = 0;
        rx_req_valid = 1'b1;
        tick();
        rx_req_valid = 1'b0;
        tick();
        checks++; if (arp_reply !== 1'b1) begin fails++; $display("FAIL mg_first got %b want 1", arp_reply); end
        tick();
        for (int i = 0; i < 3; i++) begin
            rx_req_valid = 1'b1;
            tick();
            rx_req_valid = 1'b0;
            tick();
        end
        send_frame();
        for (int k = 0; k < 60; k++) begin
            if (arp_reply) begin
                replies++;
                tick();
                send_frame();
            end else begin
                tick();
            end
        end
        checks++; if (replies !== 1) begin fails++; $display("FAIL mg_count got %0d want 1", replies); end
    endtask

    task automatic test_foreign_rsp;
        bit seen;
        int d;
        start_lookup(32'hC0A8640A);
        wait_active(10, seen);
        checks++; if (!seen) begin fails++; $display("FAIL fr_active got none want pulse"); end
        tick();
        send_frame();
        repeat (10) tick();
        send_rsp(32'hC0A86405, 48'hDEADBEEF0001);
        checks++; if (res_valid !== 1'b0 || lookup_busy !== 1'b1)
            begin fails++; $display("FAIL fr_ignore got v=%b busy=%b want 0/1", res_valid, lookup_busy); end
        wait_active(300, seen);
        d = cyc - last_cyc;
        checks++; if (!seen || d < TMO || d > TMO + 10)
            begin fails++; $display("FAIL fr_retry got seen=%b delay=%0d want 1/%0d..%0d", seen, d, TMO, TMO + 10); end
        tick();
        send_frame();
        send_rsp(32'hC0A8640A, 48'h0A0B0C0D0E0F);
        checks++; if (res_valid !== 1'b1 || res_mac !== 48'h0A0B0C0D0E0F)
            begin fails++; $display("FAIL fr_res got v=%b mac=%h want 1/0A0B0C0D0E0F", res_valid, res_mac); end
        repeat (GAP + 2) tick();
    endtask

    task automatic test_reset_mid;
        bit seen;
        start_lookup(32'hC0A80063);
        wait_active(10, seen);
        tick();
        send_frame();
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (lookup_busy !== 1'b0 || arp_active !== 1'b0 || arp_reply !== 1'b0)
            begin fails++; $display("FAIL rm_ctrl got busy=%b act=%b rep=%b want 0", lookup_busy, arp_active, arp_reply); end
        checks++; if (res_mac !== 48'd0 || res_ip !== 32'd0 || dst_ip !== 32'd0)
            begin fails++; $display("FAIL rm_data got mac=%h ip=%h dst=%h want 0", res_mac, res_ip, dst_ip); end
        tick();
        start_lookup(32'hC0A8640A);
        tick();
        checks++; if (arp_active !== 1'b1 || dst_ip !== 32'hC0A8640A)
            begin fails++; $display("FAIL rm_active got act=%b dst=%h want 1/C0A8640A", arp_active, dst_ip); end
        tick();
        send_frame();
        send_rsp(32'hC0A8640A, 48'h001122334455);
        checks++; if (res_valid !== 1'b1 || res_mac !== 48'h001122334455 || lookup_busy !== 1'b0)
            begin fails++; $display("FAIL rm_res got v=%b mac=%h busy=%b want 1/001122334455/0", res_valid, res_mac, lookup_busy); end
        repeat (GAP + 2) tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        lookup_ip    = 32'd0;
        lookup_valid = 1'b0;
        rx_req_valid = 1'b0;
        rx_rsp_valid = 1'b0;
        rx_rsp_ip    = 32'd0;
        rx_rsp_mac   = 48'd0;
        tx_ready     = 1'b1;
        tx_valid     = 1'b0;
        tx_last      = 1'b0;
        test_reset();
        test_lookup_ok();
        test_retry_fail();
        test_priority();
        test_merge();
        test_foreign_rsp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
